// File: rtl/if_defs_pkg.sv
// ============================================================================
//  Module   : if_defs (package)
//  Purpose  : Shared constants and FSM encoding for the instruction fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_defs;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_ram.sv
// ============================================================================
//  Module   : instr_ram
//  Purpose  : Word-wide instruction memory, one synchronous write port and an
//             asynchronous read port. Contents are never reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
//  Module   : if_fetch_stage
//  Purpose  : Instruction fetch stage: byte-wise program loader, instruction
//             memory and IF/ID pipeline latch with stall and flush.
//             Optional macro IF_HALT_DETECT_EN enables sticky HALT_WORD detect.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage
    import if_defs::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_pc,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_load_valid,
    input  logic [7:0]        i_load_byte,
    input  logic              i_load_clear,
    output logic              o_load_ready,
    output logic              o_run,
    output logic [ADDR_W:0]   o_word_count,
    output logic [31:0]       o_instr,
    output logic [31:0]       o_pc_plus4,
    output logic              o_valid,
    output logic              o_halt
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   c_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    fetch_state_t      r_state;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word_buf;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_word_count;
    logic [31:0]       r_instr;
    logic [31:0]       r_pc_plus4;
    logic              r_valid;
    logic              r_halt;

    logic              w_accept;
    logic              w_word_done;
    logic              w_we;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic [31:0]       w_pc_plus4;
    logic              w_pc_in_range;
    logic              w_halt_hit;

    assign w_accept      = i_load_valid && (r_state == ST_LOAD);
    assign w_word_done   = w_accept && (r_byte_cnt == 2'd3);
    // A clear or reset in the same cycle as the 4th byte wins over the write.
    assign w_we          = w_word_done && !i_load_clear && !i_reset;
    assign w_wdata       = {r_word_buf, i_load_byte};
    assign w_pc_plus4    = i_pc + 32'd4;
    assign w_pc_in_range = (i_pc[31:ADDR_W+2] == '0);

`ifdef IF_HALT_DETECT_EN
    assign w_halt_hit = (w_rdata == HALT_WORD);
`else
    assign w_halt_hit = 1'b0;
`endif

    instr_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_instr_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (i_pc[ADDR_W+1:2]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_LOAD;
            r_byte_cnt   <= 2'd0;
            r_word_buf   <= 24'd0;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_instr      <= NOP_INSTR;
            r_pc_plus4   <= 32'd0;
            r_valid      <= 1'b0;
            r_halt       <= 1'b0;
        end else if (i_load_clear) begin
            r_state      <= ST_LOAD;
            r_byte_cnt   <= 2'd0;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_instr      <= NOP_INSTR;
            r_valid      <= 1'b0;
            r_halt       <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_word_buf <= {r_word_buf[15:0], i_load_byte};
                        if (w_word_done) begin
                            r_wr_ptr     <= r_wr_ptr + 1'b1;
                            r_word_count <= r_word_count + c_CNT_ONE;
                            if ((w_wdata == HALT_WORD) || (r_wr_ptr == c_LAST_ADDR)) begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    // A detected halt freezes the latch until the next load.
                    if (r_halt) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end else if (i_flush) begin
                        r_instr    <= NOP_INSTR;
                        r_valid    <= 1'b0;
                        r_pc_plus4 <= w_pc_plus4;
                    end else if (!i_stall) begin
                        r_pc_plus4 <= w_pc_plus4;
                        if (!w_pc_in_range || w_halt_hit) begin
                            r_instr <= NOP_INSTR;
                            r_valid <= 1'b0;
                            r_halt  <= w_pc_in_range && w_halt_hit;
                        end else begin
                            r_instr <= w_rdata;
                            r_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign o_load_ready = (r_state == ST_LOAD);
    assign o_run        = (r_state == ST_RUN);
    assign o_word_count = r_word_count;
    assign o_instr      = r_instr;
    assign o_pc_plus4   = r_pc_plus4;
    assign o_valid      = r_valid;
    assign o_halt       = r_halt;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Purpose  : Directed self-checking bench for if_fetch_stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = 8;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic [31:0]       i_pc;
    logic              i_stall;
    logic              i_flush;
    logic              i_load_valid;
    logic [7:0]        i_load_byte;
    logic              i_load_clear;
    logic              o_load_ready;
    logic              o_run;
    logic [ADDR_W:0]   o_word_count;
    logic [31:0]       o_instr;
    logic [31:0]       o_pc_plus4;
    logic              o_valid;
    logic              o_halt;

    int n_total = 0;
    int n_pass  = 0;

    if_fetch_stage #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pc         (i_pc),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_load_valid (i_load_valid),
        .i_load_byte  (i_load_byte),
        .i_load_clear (i_load_clear),
        .o_load_ready (o_load_ready),
        .o_run        (o_run),
        .o_word_count (o_word_count),
        .o_instr      (o_instr),
        .o_pc_plus4   (o_pc_plus4),
        .o_valid      (o_valid),
        .o_halt       (o_halt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        i_load_valid = 1'b1;
        i_load_byte  = b;
        tick();
        i_load_valid = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        logic [31:0] v;
        v = w;
        load_byte(v[31:24]);
        load_byte(v[23:16]);
        load_byte(v[15:8]);
        load_byte(v[7:0]);
    endtask

    task automatic fetch(input logic [31:0] pc);
        i_pc = pc;
        tick();
    endtask

    task automatic pulse_clear();
        i_load_clear = 1'b1;
        tick();
        i_load_clear = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_pc = 32'd0; i_stall = 1'b0; i_flush = 1'b0;
        i_load_valid = 1'b0; i_load_byte = 8'd0; i_load_clear = 1'b0;
        tick(); tick();
        i_reset = 1'b0;

        // Reset state
        chk("rst_load_ready", 32'(o_load_ready), 32'd1);
        chk("rst_run",        32'(o_run),        32'd0);
        chk("rst_word_count", 32'(o_word_count), 32'd0);
        chk("rst_instr",      o_instr,           32'h0);
        chk("rst_pc_plus4",   o_pc_plus4,        32'h0);
        chk("rst_valid",      32'(o_valid),      32'd0);
        chk("rst_halt",       32'(o_halt),       32'd0);

        // Stall/flush are ignored while loading
        i_flush = 1'b1; i_pc = 32'h8; tick(); i_flush = 1'b0;
        chk("load_flush_pc4", o_pc_plus4, 32'h0);

        // Load a two-word program terminated by HALT
        load_word(32'h2008_0005);
        chk("t1_wc1",    32'(o_word_count), 32'd1);
        chk("t1_run0",   32'(o_run),        32'd0);
        load_word(32'hFFFF_FFFF);
        chk("t1_run1",   32'(o_run),        32'd1);
        chk("t1_ready0", 32'(o_load_ready), 32'd0);
        chk("t1_wc2",    32'(o_word_count), 32'd2);

        // Fetches
        fetch(32'h0);
        chk("t2_instr", o_instr,         32'h2008_0005);
        chk("t2_pc4",   o_pc_plus4,      32'h4);
        chk("t2_valid", 32'(o_valid),    32'd1);
        fetch(32'h400);
        chk("t2_oor_instr", o_instr,      32'h0);
        chk("t2_oor_valid", 32'(o_valid), 32'd0);
        chk("t2_oor_pc4",   o_pc_plus4,   32'h404);
        fetch(32'hFFFF_FFFC);
        chk("t2_wrap_pc4",   o_pc_plus4,   32'h0);
        chk("t2_wrap_valid", 32'(o_valid), 32'd0);

        // Stall holds the latch while PC moves
        fetch(32'h1);
        chk("t3_low_bits_instr", o_instr, 32'h2008_0005);
        chk("t3_low_bits_pc4",   o_pc_plus4, 32'h5);
        i_stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            fetch(32'(k * 4));
            chk("t3_stall_instr", o_instr,      32'h2008_0005);
            chk("t3_stall_pc4",   o_pc_plus4,   32'h5);
            chk("t3_stall_valid", 32'(o_valid), 32'd1);
        end
        i_flush = 1'b1;
        fetch(32'h8);
        chk("t3_sf_instr", o_instr,      32'h0);
        chk("t3_sf_valid", 32'(o_valid), 32'd0);
        chk("t3_sf_pc4",   o_pc_plus4,   32'hC);
        i_stall = 1'b0;
        fetch(32'h0);
        chk("t3_flush_instr", o_instr,    32'h0);
        chk("t3_flush_pc4",   o_pc_plus4, 32'h4);
        i_flush = 1'b0;

        // Fetch the HALT word
        fetch(32'h4);
`ifdef IF_HALT_DETECT_EN
        chk("t6_halt",       32'(o_halt),  32'd1);
        chk("t6_halt_valid", 32'(o_valid), 32'd0);
        chk("t6_halt_instr", o_instr,      32'h0);
        fetch(32'h0);
        chk("t6_frozen_instr", o_instr,     32'h0);
        chk("t6_frozen_halt",  32'(o_halt), 32'd1);
`else
        chk("t6_halt_instr", o_instr,      32'hFFFF_FFFF);
        chk("t6_halt_valid", 32'(o_valid), 32'd1);
        chk("t6_halt0",      32'(o_halt),  32'd0);
`endif

        // Full-memory load
        pulse_clear();
        chk("t4_clr_ready", 32'(o_load_ready), 32'd1);
        chk("t4_clr_wc",    32'(o_word_count), 32'd0);
        chk("t4_clr_valid", 32'(o_valid),      32'd0);
        chk("t4_clr_halt",  32'(o_halt),       32'd0);
        for (int k = 0; k < MEM_DEPTH - 1; k++) load_word(32'h1000_0000 | 32'(k));
        chk("t4_wc255",    32'(o_word_count), 32'd255);
        chk("t4_ready255", 32'(o_load_ready), 32'd1);
        load_word(32'h1000_00FF);
        chk("t4_wc256",  32'(o_word_count), 32'd256);
        chk("t4_run",    32'(o_run),        32'd1);
        chk("t4_ready0", 32'(o_load_ready), 32'd0);
        fetch(32'h3FC);
        chk("t4_last",  o_instr, 32'h1000_00FF);
        fetch(32'h0);
        chk("t4_first", o_instr, 32'h1000_0000);
        fetch(32'h204);
        chk("t4_mid",   o_instr, 32'h1000_0081);

        // Clear after two bytes discards the partial word
        pulse_clear();
        load_byte(8'h12);
        load_byte(8'h34);
        pulse_clear();
        chk("t4_pclr_wc", 32'(o_word_count), 32'd0);
        load_word(32'hAABB_CCDD);
        chk("t4_pclr_wc1", 32'(o_word_count), 32'd1);
        load_word(32'hFFFF_FFFF);
        fetch(32'h0);
        chk("t4_pclr_instr", o_instr, 32'hAABB_CCDD);

        // Reset mid-load
        pulse_clear();
        load_word(32'h1122_3344);
        load_byte(8'h55);
        load_byte(8'h66);
        chk("t5_wc1", 32'(o_word_count), 32'd1);
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        chk("t5_ready", 32'(o_load_ready), 32'd1);
        chk("t5_wc0",   32'(o_word_count), 32'd0);
        load_word(32'h0102_0304);
        load_word(32'hFFFF_FFFF);
        chk("t5_run", 32'(o_run), 32'd1);
        fetch(32'h0);
        chk("t5_mem0", o_instr,      32'h0102_0304);
        chk("t5_val0", 32'(o_valid), 32'd1);
        fetch(32'h4);
`ifdef IF_HALT_DETECT_EN
        chk("t5_mem1_halt", 32'(o_halt), 32'd1);
`else
        chk("t5_mem1", o_instr, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
